// File: rtl/ay_bus_master.sv
// Bus initiator for the AY/YM PSG: turns single register-access requests into latch/write/read bus cycles.
// Optional address cache is enabled by defining AYM_ADDR_CACHE_EN.
module ay_bus_master #(
   parameter int unsigned HOLD_TICKS = 1,
   parameter int unsigned GAP_TICKS  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clken,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_wr,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       a8,
   output logic       bdir,
   output logic       bc2,
   output logic       bc1,
   output logic [7:0] bus_dout,
   input  logic [7:0] bus_din,
   input  logic       bus_oe_n,
   output logic       busy,
   input  logic       cache_inval
);

   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);

   localparam logic [2:0] BUS_LATCH    = 3'b111;
   localparam logic [2:0] BUS_WRITE    = 3'b110;
   localparam logic [2:0] BUS_READ     = 3'b011;
   localparam logic [2:0] BUS_INACTIVE = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE, S_LATCH, S_GAP1, S_WRITE, S_READ, S_GAP2
   } state_t;

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          wr_q, wr_d;
   logic [7:0]    addr_q, addr_d;
   logic [7:0]    data_q, data_d;
   logic          req_ready_d, busy_d, rsp_valid_d, a8_d;
   logic [7:0]    rsp_data_d, bus_dout_d;
   logic [2:0]    code_d;
   logic          hit_c;

`ifdef AYM_ADDR_CACHE_EN
   logic [7:0] last_addr;
   logic       cache_ok;
   logic       latch_done_c;

   assign latch_done_c = (state == S_LATCH) && clken && (cnt == HOLD_LAST);
   assign hit_c        = cache_ok && (req_addr == last_addr);

   // Remember the most recently latched address; an invalidate wins over a completing latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_addr <= 8'h00;
         cache_ok  <= 1'b0;
      end else begin
         if (latch_done_c) last_addr <= addr_q;
         if (cache_inval)       cache_ok <= 1'b0;
         else if (latch_done_c) cache_ok <= 1'b1;
      end
   end
`else
   logic unused_cache_inval;
   assign unused_cache_inval = cache_inval;
   assign hit_c              = 1'b0;
`endif

   // Next state, phase counter and next registered outputs
   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      wr_d        = wr_q;
      addr_d      = addr_q;
      data_d      = data_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data;
      a8_d        = 1'b0;
      code_d      = BUS_INACTIVE;
      bus_dout_d  = bus_dout;
      req_ready_d = 1'b0;
      busy_d      = 1'b1;

      case (state)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               wr_d    = req_wr;
               addr_d  = req_addr;
               data_d  = req_data;
               state_d = hit_c ? (req_wr ? S_WRITE : S_READ) : S_LATCH;
            end
         end
         S_LATCH: if (clken && cnt == HOLD_LAST) state_d = S_GAP1;
         S_GAP1:  if (clken && cnt == GAP_LAST)  state_d = wr_q ? S_WRITE : S_READ;
         S_WRITE: if (clken && cnt == HOLD_LAST) state_d = S_GAP2;
         S_READ: begin
            if (clken && cnt == HOLD_LAST) begin
               state_d     = S_GAP2;
               rsp_valid_d = 1'b1;
               rsp_data_d  = bus_oe_n ? 8'hFF : bus_din;
            end
         end
         S_GAP2:  if (clken && cnt == GAP_LAST)  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (state_d != state)                 cnt_d = '0;
      else if (clken && state != S_IDLE)    cnt_d = cnt + CW'(1);

      // Bus outputs reflect the state being entered so they change with the state register
      case (state_d)
         S_IDLE: begin
            req_ready_d = 1'b1;
            busy_d      = 1'b0;
         end
         S_LATCH: begin
            a8_d       = 1'b1;
            code_d     = BUS_LATCH;
            bus_dout_d = addr_d;
         end
         S_WRITE: begin
            a8_d       = 1'b1;
            code_d     = BUS_WRITE;
            bus_dout_d = data_d;
         end
         S_READ: begin
            a8_d       = 1'b1;
            code_d     = BUS_READ;
            bus_dout_d = 8'h00;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_IDLE;
         cnt              <= '0;
         wr_q             <= 1'b0;
         addr_q           <= 8'h00;
         data_q           <= 8'h00;
         req_ready        <= 1'b1;
         busy             <= 1'b0;
         rsp_valid        <= 1'b0;
         rsp_data         <= 8'hFF;
         a8               <= 1'b0;
         {bdir, bc2, bc1} <= BUS_INACTIVE;
         bus_dout         <= 8'h00;
      end else begin
         state            <= state_d;
         cnt              <= cnt_d;
         wr_q             <= wr_d;
         addr_q           <= addr_d;
         data_q           <= data_d;
         req_ready        <= req_ready_d;
         busy             <= busy_d;
         rsp_valid        <= rsp_valid_d;
         rsp_data         <= rsp_data_d;
         a8               <= a8_d;
         {bdir, bc2, bc1} <= code_d;
         bus_dout         <= bus_dout_d;
      end
   end

endmodule

// File: doc/ay_bus_master.md
Name: ay_bus_master

Overview:
- Bus initiator for the AY/YM PSG register interface. Drives the a8/bdir/bc2/bc1 bus and the 8-bit data bus.
- Converts single register-access requests (valid/ready) into address-latch, write and read bus cycles, paced by the clock enable.
- Sits between the host sequencers (tape/music player, test harness) and the PSG instance, in place of the Z80 bus decode.

Parameters:
HOLD_TICKS, 1, number of clken ticks each active bus phase (latch/write/read) is held; legal 1..15
GAP_TICKS, 1, number of clken ticks of inactive bus between phases and after a cycle; legal 1..15

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clken  in  1  bus timing enable; all phase counting happens only on clk edges with clken=1
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_wr  in  1  1=write, 0=read
req_addr  in  8  full 8-bit register address (all bits driven on latch)
req_data  in  8  write data
rsp_valid  out  1  one-clk pulse: read data available
rsp_data  out  8  read result, held until the next read completes
a8  out  1  PSG chip select
bdir  out  1  PSG BDIR
bc2  out  1  PSG BC2
bc1  out  1  PSG BC1
bus_dout  out  8  data to PSG din
bus_din  in  8  data from PSG dout
bus_oe_n  in  1  PSG output enable (0 = bus_din valid)
busy  out  1  high from acceptance until return to IDLE
cache_inval  in  1  forces the next access to perform an address latch (used only with the optional feature)

Behaviour:
- Reset (async, rst_n=0) forces: state=IDLE, req_ready=1, busy=0, rsp_valid=0, rsp_data=8'hFF, a8=0, {bdir,bc2,bc1}=3'b010 (inactive), bus_dout=8'h00, tick counter=0.
  - Reset mid-cycle aborts the cycle immediately; the bus goes inactive asynchronously.
- Bus codes {bdir,bc2,bc1}:
  - LATCH=3'b111
  - WRITE=3'b110
  - READ=3'b011
  - INACTIVE=3'b010
- a8=1 during LATCH/WRITE/READ phases only; a8=0 otherwise.
- Acceptance:
  - In IDLE, req_ready=1.
  - A handshake (req_valid & req_ready on a clk edge, clken not required) captures req_wr/addr/data.
  - It clears req_ready and sets busy on the same edge.
  - The next state is LATCH.
- States and transitions (each transition happens on a clken tick when the phase counter reaches its terminal count):
  - IDLE: bus INACTIVE, a8=0.
  - LATCH: bus LATCH, bus_dout=addr, held HOLD_TICKS ticks -> GAP1.
  - GAP1: bus INACTIVE, a8=0, bus_dout unchanged, GAP_TICKS ticks -> WRITE if wr, else READ.
  - WRITE: bus WRITE, bus_dout=data, HOLD_TICKS ticks -> GAP2.
  - READ: bus READ, bus_dout=8'h00, HOLD_TICKS ticks.
    - On the final tick, rsp_data <= bus_oe_n ? 8'hFF : bus_din.
    - rsp_valid=1 for exactly one clk.
    - -> GAP2.
  - GAP2: bus INACTIVE, GAP_TICKS ticks -> IDLE (req_ready=1, busy=0 on the following clk).
- Total latency in clken ticks, from acceptance to ready: 2*HOLD_TICKS + 2*GAP_TICKS. This is 4 with the defaults.
- Ticks are counted from the first clken after acceptance. A clken coinciding with the acceptance edge is not counted.
- If clken is held low, all outputs hold indefinitely. No timeout.
- The phase counter is 4 bits and resets to 0 on every state change; it never wraps because HOLD/GAP ≤ 15.
- req_* inputs are ignored while busy. A held req_valid is accepted on the first IDLE clk.

Optional Feature:
- Macro AYM_ADDR_CACHE_EN.
- Defined:
  - The block keeps last_addr plus a cache_ok flag.
  - cache_ok is set on completion of every LATCH phase.
  - cache_ok is cleared by reset or by cache_inval=1 on any clk (cache_inval has priority over the set).
  - On acceptance, if cache_ok=1 and req_addr==last_addr, LATCH and GAP1 are skipped and the next state is WRITE/READ directly.
  - Cached latency is HOLD_TICKS + GAP_TICKS.
- Undefined: every access latches the address; cache_inval is ignored; last_addr/cache_ok do not exist.

Test Plan:
- Reset with defaults -> bus=3'b010, a8=0, req_ready=1, rsp_data=8'hFF, busy=0.
- clken every clk; write addr=8'h07 data=8'h38 -> one tick 111/dout=07, one tick 010, one tick 110/dout=38, one tick 010; ready returns after 4 ticks.
- Read addr=8'h0E, PSG returns bus_din=8'hA5 with bus_oe_n=0 -> rsp_valid single pulse with rsp_data=8'hA5. Same read with bus_oe_n=1 -> rsp_data=8'hFF.
- HOLD_TICKS=3, GAP_TICKS=2, clken every 4th clk -> each phase spans exactly 3 (resp. 2) clken ticks. Asserting rst_n=0 during WRITE -> bus 010 and a8=0 with no clk edge needed.
- AYM_ADDR_CACHE_EN:
  - Two writes to 8'h08 -> the second shows no 111 phase and takes 2 ticks.
  - Pulse cache_inval, then write 8'h08 again -> 111 phase present.
  - Write 8'h09 -> latch present.
- req_valid held high continuously for 3 writes -> 3 back-to-back cycles; no request lost or duplicated; req_ready low throughout each cycle.
